phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Instruction phase sequencer for the CPU control unit. Generates a one-hot 10-phase strobe (decade-counter style) that steps the datapath through each instruction, with per-instruction length, a stall input, and a halt/single-step handshake for the debug front panel. Sits between the clock and reset source and the microcode decode logic, replacing a free-running decade counter with early reset.

## Interface
Parameters:
- NPHASE, 10, number of decoded phase outputs; fixed at 10, not overridable.
- RESET_LEN, 10, instruction length in effect before the first length sample.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- _mr  in  1  asynchronous, active-low master reset.
- _stall  in  1  active-low hold. While 0, phase, length and state are frozen.
- len  in  4  phase count of the current instruction. Sampled only while in phase 0.
- halt_req  in  1  active-high request to stop at the next instruction boundary.
- step  in  1  active-high single-step request. Honoured only while halted.
- phase  out  10  one-hot current phase; bit n high means phase n.
- _co  out  1  decade carry: 1 for phases 0–4, 0 for phases 5–9.
- _last  out  1  active-low; 0 during the final phase of the instruction.
- halted  out  1  high while parked in phase 0 in the HALTED state.

## Operation
- Internal count 0..9 with a one-hot decode to `phase`. Outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs except `len` → `_last`, which is not used (see below).
- Length clamp: `len` < 2 is treated as 2, and `len` > 10 is treated as 10. The effective length L is latched into len_q on the edge that leaves phase 0.
- Phase 0 is never last, because the minimum length is 2. This is why `_last` depends only on count and len_q.
- `_last` = 0 when count == len_q−1 and count != 0.
- States:
  - RUN: advance by one each edge. On the last phase, go to phase 0. If `halt_req` = 1 at that edge, move to HALTED; otherwise stay in RUN.
  - HALTED: count held at 0 and `halted` = 1.
    - If `halt_req` = 0, move to RUN and begin phase 0 → 1 on the following edge.
    - Else if `step` = 1, move to STEP.
    - `step` and `halt_req` are level-sampled each edge.
  - STEP: behaves like RUN for exactly one instruction, then returns to HALTED at the boundary regardless of `halt_req`.
- Leaving HALTED takes one edge: the phase 0 → 1 advance occurs on the edge after the state change. Phase 0 is therefore held for at least one full cycle with `halted` = 0, so `len` is sampled cleanly.
- Priority: `_mr` over `_stall` over everything else. A stall in any state freezes the state; `halt_req` and `step` are ignored during a stall.
- `halt_req` asserted mid-instruction: the instruction completes in full. There is no abort.
- `halt_req` asserted and dropped between boundaries is not latched; only its level at the boundary edge counts.

## Timing
- Reset values (asynchronous, immediate on `_mr` = 0):
  - `phase` = 10'b0000000001
  - count = 0
  - len_q = RESET_LEN
  - state = RUN
  - `_co` = 1, `_last` = 1, `halted` = 0
- After `_mr` rises, the first advance is on the first rising edge.
- Reset mid-instruction: immediate return to phase 0 in RUN. Any pending halt or step is discarded.
- Instruction of length L in RUN occupies exactly L cycles, phases 0..L−1. Back-to-back instructions have no gap cycle.
- Wrap: with L = 10, phase 9 → phase 0 on the next edge, `_co` returns to 1, and `_last` is 0 during phase 9.
- `halted` rises on the same edge that enters phase 0 from the last phase. It falls on the edge that exits HALTED.

## Structure
- Package `phase_pkg` holds:
  - the state enum {RUN, HALTED, STEP}
  - constants NPHASE = 10, MINLEN = 2, MAXLEN = 10
  - the length-clamp function
- Sub-module `phase_counter`: 0..9 counter with async active-low clear, synchronous clear, and enable. It outputs the one-hot `phase` and `_co`.
- The top level holds the FSM, len_q and the `_last` compare.

## Test plan
- Reset, then `len` = 10, free-running: `phase` walks 1, 2, 4 … 512 → 1. `_co` = 1 for phases 0–4 and 0 for 5–9. `_last` = 0 only at phase 9.
- Mixed lengths `len` = 3, 0, 15: instructions last 3, 2 and 10 cycles. `_last` lows occur at phases 2, 1 and 9 respectively.
- `_stall` = 0 for 3 cycles at phase 4: `phase` stays 10'b0000010000 for those 3 cycles, then resumes at phase 5. Total instruction length grows by 3.
- `halt_req` = 1 raised at phase 2 with `len` = 5:
  - phases 3 and 4 complete, then the sequencer enters phase 0 with `halted` = 1 and holds.
  - dropping `halt_req` gives `halted` = 0 after one edge, then phase 1 on the next edge.
- While halted, pulse `step` for 1 cycle with `halt_req` held high at `len` = 4: exactly one 4-phase instruction runs, then `halted` = 1 again at phase 0.
- Assert `_mr` = 0 asynchronously at phase 7 in STEP: outputs go immediately to the reset values, state = RUN, and no re-halt follows.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared types, constants and the instruction-length clamp for the phase sequencer.
package phase_pkg;

  localparam int unsigned NPHASE = 10;
  localparam int unsigned MINLEN = 2;
  localparam int unsigned MAXLEN = 10;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_e;

  // Lengths below MINLEN stretch up; above MAXLEN saturate at one full decade.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
    if (l < CNT_W'(MINLEN)) return CNT_W'(MINLEN);
    if (l > CNT_W'(MAXLEN)) return CNT_W'(MAXLEN);
    return l;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and its controller (decode logic, debug panel).
interface phase_sequencer_if;
  import phase_pkg::*;

  logic              _stall;
  logic [CNT_W-1:0]  len;
  logic              halt_req;
  logic              step;
  logic [NPHASE-1:0] phase;
  logic              _co;
  logic              _last;
  logic              halted;

  modport master (
    output _stall, len, halt_req, step,
    input  phase, _co, _last, halted
  );

  modport slave (
    input  _stall, len, halt_req, step,
    output phase, _co, _last, halted
  );
endinterface

// File: rtl/phase_counter.sv
// Decade counter 0..9 with async/sync clear and enable; registered one-hot phase and carry.
module phase_counter
  import phase_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  count_nxt_c,
  output logic [NPHASE-1:0] phase_o,
  output logic              co_o
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              co_q, co_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == CNT_W'(NPHASE - 1)) ? '0 : count_q + CNT_W'(1);
    end
    phase_d = NPHASE'(1) << count_d;
    co_d    = (count_d < CNT_W'(NPHASE / 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= NPHASE'(1);
      co_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      co_q    <= co_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_c = count_d;
  assign phase_o     = phase_q;
  assign co_o        = co_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: per-instruction length, stall, and halt/single-step at instruction boundaries.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int unsigned RESET_LEN = 10
) (
  input  logic             clk,
  input  logic             _mr,
  phase_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count, count_nxt;
  logic             last_n_q, last_n_d;
  logic             halted_q, halted_d;
  logic             clr, en, is_last;

  phase_counter u_counter (
    .clk         (clk),
    .rst_n       (_mr),
    .clr_i       (clr),
    .en_i        (en),
    .count_o     (count),
    .count_nxt_c (count_nxt),
    .phase_o     (bus.phase),
    .co_o        (bus._co)
  );

  // Phase 0 is never last since the minimum length is 2.
  assign is_last = (count == len_q - CNT_W'(1)) && (count != '0);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    clr     = 1'b0;
    en      = 1'b0;
    if (bus._stall) begin
      unique case (state_q)
        RUN, STEP: begin
          if (is_last) begin
            clr     = 1'b1;
            state_d = ((state_q == STEP) || bus.halt_req) ? HALTED : RUN;
          end else begin
            en = 1'b1;
            if (count == '0) len_d = clamp_len(bus.len);
          end
        end
        HALTED: begin
          if (!bus.halt_req)  state_d = RUN;
          else if (bus.step)  state_d = STEP;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Status outputs are precomputed from next-state so they line up with the registered phase.
  assign last_n_d = !((count_nxt == len_d - CNT_W'(1)) && (count_nxt != '0));
  assign halted_d = (state_d == HALTED);

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state_q  <= RUN;
      len_q    <= CNT_W'(RESET_LEN);
      last_n_q <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      last_n_q <= last_n_d;
      halted_q <= halted_d;
    end
  end

  assign bus._last  = last_n_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: instruction-level reference model plus directed literal checks.
module tb_phase_sequencer;

  logic clk;
  logic mr_n;
  phase_sequencer_if bus ();

  phase_sequencer dut (
    .clk (clk),
    ._mr (mr_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Reference model: position within the current instruction and its effective length.
  int m_pos;
  int m_len;
  bit m_halted;
  bit m_stepping;

  function automatic int eff_len(input int l);
    return (l < 2) ? 2 : ((l > 10) ? 10 : l);
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_len = 10; m_halted = 1'b0; m_stepping = 1'b0;
  endfunction

  function automatic void model_step();
    if (!bus._stall) return;
    if (m_halted) begin
      if (!bus.halt_req) begin m_halted = 1'b0; m_stepping = 1'b0; end
      else if (bus.step) begin m_halted = 1'b0; m_stepping = 1'b1; end
    end else if (m_pos == m_len - 1 && m_pos != 0) begin
      m_pos = 0;
      if (m_stepping || bus.halt_req) m_halted = 1'b1;
      m_stepping = 1'b0;
    end else begin
      if (m_pos == 0) m_len = eff_len(int'(bus.len));
      m_pos++;
    end
  endfunction

  always @(posedge clk) begin
    if (!mr_n) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("phase",  int'(bus.phase),  1 << m_pos);
      chk("_co",    int'(bus._co),    (m_pos < 5) ? 1 : 0);
      chk("_last",  int'(bus._last),  (m_pos == m_len - 1 && m_pos != 0) ? 0 : 1);
      chk("halted", int'(bus.halted), int'(m_halted));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int i = 0;
    while (m_pos != p && i < 60) begin @(negedge clk); i++; end
    chk("wait_phase", int'(bus.phase), 1 << p);
  endtask

  task automatic wait_halted();
    int i = 0;
    while (!m_halted && i < 60) begin @(negedge clk); i++; end
    chk("wait_halted", int'(bus.halted), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  int lens[3]     = '{3, 0, 15};
  int last_ph[3]  = '{2, 1, 9};
  int eff[3]      = '{3, 2, 10};

  initial begin
    mr_n = 1'b0;
    bus._stall = 1'b1; bus.len = 4'd10; bus.halt_req = 1'b0; bus.step = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_phase",  int'(bus.phase), 1);
    chk("rst_co",     int'(bus._co), 1);
    chk("rst_last",   int'(bus._last), 1);
    chk("rst_halted", int'(bus.halted), 0);
    mr_n = 1'b1;
    check_en = 1'b1;

    // Free-running decade at len 10.
    tick(4);  chk("free_ph4", int'(bus.phase), 16);  chk("free_co4", int'(bus._co), 1);
    tick(1);  chk("free_ph5", int'(bus.phase), 32);  chk("free_co5", int'(bus._co), 0);
    tick(4);  chk("free_ph9", int'(bus.phase), 512); chk("free_last9", int'(bus._last), 0);
    tick(1);  chk("free_wrap", int'(bus.phase), 1);  chk("free_wrap_co", int'(bus._co), 1);

    // Mixed lengths with clamping.
    for (int k = 0; k < 3; k++) begin
      int i;
      wait_pos(0);
      bus.len = 4'(lens[k]);
      i = 0;
      while (bus._last !== 1'b0 && i < 20) begin @(negedge clk); i++; end
      chk("last_phase", int'(bus.phase), 1 << last_ph[k]);
      chk("inst_cycles", i, eff[k] - 1);
    end

    // Stall for 3 cycles at phase 4.
    bus.len = 4'd10;
    wait_pos(4);
    bus._stall = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(1); chk("stall_hold", int'(bus.phase), 16); end
    bus._stall = 1'b1;
    tick(1); chk("stall_resume", int'(bus.phase), 32);

    // Halt request mid-instruction at len 5.
    wait_pos(0);
    bus.len = 4'd5;
    wait_pos(2);
    bus.halt_req = 1'b1;
    tick(3); chk("halt_enter", int'(bus.halted), 1); chk("halt_ph", int'(bus.phase), 1);
    tick(3); chk("halt_hold", int'(bus.halted), 1);
    bus.halt_req = 1'b0;
    tick(1); chk("unhalt", int'(bus.halted), 0); chk("unhalt_ph0", int'(bus.phase), 1);
    tick(1); chk("unhalt_ph1", int'(bus.phase), 2);

    // Single step of a 4-phase instruction.
    bus.halt_req = 1'b1;
    wait_halted();
    bus.len = 4'd4;
    bus.step = 1'b1;
    tick(1); bus.step = 1'b0;
    chk("step_leave", int'(bus.halted), 0); chk("step_ph0", int'(bus.phase), 1);
    tick(4); chk("step_rehalt", int'(bus.halted), 1); chk("step_rehalt_ph", int'(bus.phase), 1);

    // Asynchronous reset at phase 7 while stepping.
    bus.len = 4'd10;
    bus.step = 1'b1;
    tick(1); bus.step = 1'b0;
    tick(7); chk("step_ph7", int'(bus.phase), 128);
    #2 mr_n = 1'b0;
    model_reset();
    #1;
    chk("arst_phase",  int'(bus.phase), 1);
    chk("arst_co",     int'(bus._co), 1);
    chk("arst_last",   int'(bus._last), 1);
    chk("arst_halted", int'(bus.halted), 0);
    bus.halt_req = 1'b0;
    @(negedge clk);
    #2 mr_n = 1'b1;
    tick(3); chk("post_rst_ph3", int'(bus.phase), 8); chk("post_rst_run", int'(bus.halted), 0);
    tick(12);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        #2 mr_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2 mr_n = 1'b1;
      end else begin
        bus._stall = ($urandom_range(0, 9) != 0);
        bus.len    = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) bus.halt_req = ~bus.halt_req;
        bus.step   = ($urandom_range(0, 3) == 0);
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
